// File: rtl/gamma_loader.sv
// gamma_loader: write-side sequencer for the 22-bit gamma LUT bus.
// Fills an identity ramp, arbitrates host writes, gates gamma_en.
module gamma_loader #(
    parameter bit RAMP_ON_RESET = 1'b1
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic [9:0] host_addr,
    input  logic [7:0] host_data,
    input  logic       host_valid,
    output logic       host_ready,
    input  logic       ramp_start,
    input  logic       gamma_on,
    input  logic       vbl_only,
    input  logic       vblank,
    output logic       busy,
    output logic       table_valid,
    output logic       err,
    output logic       gamma_supported,
    inout  wire [21:0] gamma_bus
);

    typedef enum logic [1:0] {
        IDLE,
        RAMP,
        RAMP_WAIT
    } state_t;

    localparam logic [9:0] LAST_IDX = 10'd767;
    localparam logic [9:0] LUT_SIZE = 10'd768;

    state_t     state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    logic [9:0] addr_q, addr_d;
    logic [7:0] val_q, val_d;
    logic       hstb_q, hstb_d;
    logic       tv_q, tv_d;
    logic       err_q, err_d;
    logic       gen_q, gen_d;
    logic       pend_q, pend_d;

    logic       gate;
    logic       start;
    logic       accept;
    logic       ramp_wr;
    logic       strobe;
    logic [9:0] wr_addr;
    logic [7:0] wr_val;

    // Handshake, gating and write-source selection.
    always_comb begin
        gate       = ~vbl_only | vblank;
        start      = ramp_start | pend_q;
        host_ready = (state_q == IDLE) & ~start & gate & reset_n;
        accept     = host_valid & host_ready;
        ramp_wr    = (state_q != IDLE) & gate;
        strobe     = ramp_wr | hstb_q;
        wr_addr    = ramp_wr ? cnt_q : addr_q;
        wr_val     = ramp_wr ? cnt_q[7:0] : val_q;
    end

    // Next-state logic: ramp sequencing, host writes, status flags.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        val_d   = val_q;
        hstb_d  = 1'b0;
        tv_d    = tv_q;
        err_d   = err_q;
        pend_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = gate ? RAMP : RAMP_WAIT;
                    cnt_d   = 10'd0;
                    tv_d    = 1'b0;
                end else if (accept) begin
                    if (host_addr >= LUT_SIZE) begin
                        err_d = 1'b1;
                    end else begin
                        hstb_d = 1'b1;
                        addr_d = host_addr;
                        val_d  = host_data;
                    end
                end
            end
            RAMP, RAMP_WAIT: begin
                if (ramp_wr) begin
                    addr_d = cnt_q;
                    val_d  = cnt_q[7:0];
                    if (cnt_q == LAST_IDX) begin
                        state_d = IDLE;
                        cnt_d   = 10'd0;
                        tv_d    = 1'b1;
                    end else begin
                        state_d = RAMP;
                        cnt_d   = cnt_q + 10'd1;
                    end
                end else begin
                    state_d = RAMP_WAIT;
                end
            end
            default: state_d = IDLE;
        endcase
        gen_d = gamma_on & tv_q & gamma_supported
              & (state_q == IDLE) & ~start;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 10'd0;
            addr_q  <= 10'd0;
            val_q   <= 8'd0;
            hstb_q  <= 1'b0;
            tv_q    <= 1'b0;
            err_q   <= 1'b0;
            gen_q   <= 1'b0;
            pend_q  <= RAMP_ON_RESET;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            val_q   <= val_d;
            hstb_q  <= hstb_d;
            tv_q    <= tv_d;
            err_q   <= err_d;
            gen_q   <= gen_d;
            pend_q  <= pend_d;
        end
    end

    assign busy            = (state_q != IDLE);
    assign table_valid     = tv_q;
    assign err             = err_q;
    assign gamma_supported = gamma_bus[21];

    assign gamma_bus[20]   = clk_sys;
    assign gamma_bus[19]   = gen_q;
    assign gamma_bus[18]   = strobe;
    assign gamma_bus[17:8] = wr_addr;
    assign gamma_bus[7:0]  = wr_val;

endmodule

// File: tb/tb_gamma_loader.sv
// tb_gamma_loader: directed self-checking bench for gamma_loader.
// Drives and samples on the falling clock edge.
module tb_gamma_loader;

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] host_addr = '0;
    logic [7:0] host_data = '0;
    logic       host_valid = 1'b0;
    logic       host_ready;
    logic       ramp_start = 1'b0;
    logic       gamma_on = 1'b0;
    logic       vbl_only = 1'b0;
    logic       vblank = 1'b0;
    logic       busy;
    logic       table_valid;
    logic       err;
    logic       gamma_supported;
    logic       sup = 1'b1;
    wire [21:0] gbus;

    int n_chk = 0;
    int n_fail = 0;

    assign gbus[21] = sup;

    gamma_loader #(.RAMP_ON_RESET(1'b1)) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .host_addr      (host_addr),
        .host_data      (host_data),
        .host_valid     (host_valid),
        .host_ready     (host_ready),
        .ramp_start     (ramp_start),
        .gamma_on       (gamma_on),
        .vbl_only       (vbl_only),
        .vblank         (vblank),
        .busy           (busy),
        .table_valid    (table_valid),
        .err            (err),
        .gamma_supported(gamma_supported),
        .gamma_bus      (gbus)
    );

    always #5 clk_sys = ~clk_sys;

    wire       stb  = gbus[18];
    wire       gen  = gbus[19];
    wire [9:0] badr = gbus[17:8];
    wire [7:0] bval = gbus[7:0];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered on the negedge of the cycle that should carry index 0.
    // Returns on the negedge one cycle after index 767 was written.
    task automatic ramp_watch(input bit pat, input int budget,
                              output int nwr, output int bad);
        int  idx;
        bit  done;
        logic g;
        idx  = 0;
        bad  = 0;
        done = 0;
        for (int cyc = 0; cyc < budget && !done; cyc++) begin
            if (pat) vblank = ((cyc % 300) < 100);
            #1;
            g = ~vbl_only | vblank;
            if (stb !== g) bad++;
            if (gen !== 1'b0 || busy !== 1'b1) bad++;
            if (stb === 1'b1) begin
                if (badr !== idx[9:0] || bval !== idx[7:0]) bad++;
                if (idx == 767) done = 1;
                idx++;
            end
            @(negedge clk_sys);
        end
        nwr = idx;
        if (!done) bad++;
    endtask

    int nwr;
    int bad;

    initial begin
        gamma_on = 1'b1;
        repeat (3) @(negedge clk_sys);
        #1;
        chk("rst_strobe", stb, 0);
        chk("rst_addr", badr, 0);
        chk("rst_val", bval, 0);
        chk("rst_gen", gen, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tv", table_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", host_ready, 0);

        // Auto ramp after reset release, gate open.
        reset_n = 1'b1;
        #1;
        chk("rel_busy", busy, 0);
        @(negedge clk_sys);
        ramp_watch(1'b0, 900, nwr, bad);
        chk("boot_count", nwr, 768);
        chk("boot_bad", bad, 0);
        #1;
        chk("boot_tv", table_valid, 1);
        chk("boot_busy", busy, 0);
        chk("boot_gen_lo", gen, 0);
        @(negedge clk_sys);
        #1;
        chk("boot_gen_hi", gen, 1);

        // Ramp confined to vblank, 100 on / 200 off.
        vbl_only   = 1'b1;
        vblank     = 1'b1;
        ramp_start = 1'b1;
        #1;
        chk("vbl_ready", host_ready, 0);
        @(negedge clk_sys);
        ramp_start = 1'b0;
        ramp_watch(1'b1, 3000, nwr, bad);
        chk("vbl_count", nwr, 768);
        chk("vbl_bad", bad, 0);
        #1;
        chk("vbl_tv", table_valid, 1);
        vbl_only = 1'b0;
        repeat (2) @(negedge clk_sys);

        // Five back-to-back host writes with gamma enabled.
        for (int i = 0; i <= 5; i++) begin
            if (i < 5) begin
                host_valid = 1'b1;
                host_addr  = 10'(10 + i);
                host_data  = 8'(8'h80 + i);
            end else begin
                host_valid = 1'b0;
            end
            #1;
            if (i < 5) chk("hw_ready", host_ready, 1);
            if (i > 0) begin
                chk("hw_stb", stb, 1);
                chk("hw_addr", badr, 10 + i - 1);
                chk("hw_val", bval, 8'h80 + i - 1);
            end
            chk("hw_gen", gen, 1);
            @(negedge clk_sys);
        end
        #1;
        chk("hw_idle_stb", stb, 0);
        chk("hw_hold_addr", badr, 14);
        chk("hw_hold_val", bval, 8'h84);
        chk("hw_tv", table_valid, 1);

        // ramp_start beats a host write in the same cycle.
        ramp_start = 1'b1;
        host_valid = 1'b1;
        host_addr  = 10'd5;
        host_data  = 8'h55;
        #1;
        chk("pri_ready", host_ready, 0);
        @(negedge clk_sys);
        ramp_start = 1'b0;
        ramp_watch(1'b0, 900, nwr, bad);
        chk("pri_count", nwr, 768);
        chk("pri_bad", bad, 0);
        #1;
        chk("pri_busy", busy, 0);
        chk("pri_ready_after", host_ready, 1);
        @(negedge clk_sys);
        host_valid = 1'b0;
        #1;
        chk("pri_stb", stb, 1);
        chk("pri_addr", badr, 5);
        chk("pri_val", bval, 8'h55);
        @(negedge clk_sys);

        // Out-of-range host write sets sticky err.
        chk("oor_err0", err, 0);
        host_valid = 1'b1;
        host_addr  = 10'd800;
        host_data  = 8'h11;
        #1;
        chk("oor_ready", host_ready, 1);
        @(negedge clk_sys);
        host_addr = 10'd3;
        host_data = 8'h33;
        #1;
        chk("oor_stb", stb, 0);
        chk("oor_err", err, 1);
        @(negedge clk_sys);
        host_valid = 1'b0;
        #1;
        chk("ok3_stb", stb, 1);
        chk("ok3_addr", badr, 3);
        chk("ok3_val", bval, 8'h33);
        chk("ok3_err", err, 1);
        @(negedge clk_sys);

        // Reset at ramp index 400.
        ramp_start = 1'b1;
        @(negedge clk_sys);
        ramp_start = 1'b0;
        repeat (400) @(negedge clk_sys);
        #1;
        chk("mid_addr", badr, 400);
        chk("mid_stb", stb, 1);
        reset_n = 1'b0;
        @(negedge clk_sys);
        #1;
        chk("mrst_stb", stb, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_tv", table_valid, 0);
        chk("mrst_err", err, 0);
        chk("mrst_gen", gen, 0);
        sup = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        #1;
        chk("sup_out", gamma_supported, 0);
        @(negedge clk_sys);
        ramp_watch(1'b0, 900, nwr, bad);
        chk("rerun_count", nwr, 768);
        chk("rerun_bad", bad, 0);
        repeat (3) @(negedge clk_sys);
        #1;
        chk("nosup_gen", gen, 0);
        chk("nosup_tv", table_valid, 1);
        sup = 1'b1;
        repeat (2) @(negedge clk_sys);
        #1;
        chk("sup_gen", gen, 1);
        gamma_on = 1'b0;
        @(negedge clk_sys);
        #1;
        chk("off_gen", gen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
